// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32 memory stage
//   funct3 load/store encodings, access-size field values, writeback mux
//   selects, and the bus-access FSM state type.
package riscv_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    typedef enum logic [1:0] {IDLE, WAIT, ABORT} mem_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment for loads and stores
//   in  funct3      access size (bits 1:0) and unsigned flag (bit 2)
//   in  addr        low two address bits
//   in  wdata       raw store data
//   in  rdata       raw bus read data
//   out be          byte enables
//   out store_data  store data replicated across lanes
//   out load_data   selected lane, sign- or zero-extended
//   out misalign    access not naturally aligned for its size
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        misalign
);
    logic        is_h;
    logic        is_w;
    logic        sext;
    logic [31:0] lane;
    assign is_h       = funct3[1:0] == SZ_HALF;
    assign is_w       = funct3[1];
    assign sext       = !funct3[2];
    assign misalign   = (is_h && addr[0]) || (is_w && addr != 2'b00);
    assign be         = is_w ? 4'b1111 : is_h ? 4'b0011 << addr : 4'b0001 << addr;
    assign store_data = is_w ? wdata : is_h ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    // Shift the addressed lane down to bit 0 before extending.
    assign lane       = rdata >> {addr, 3'b000};
    assign load_data  = is_w ? lane
                      : is_h ? {{16{lane[15] & sext}}, lane[15:0]}
                      : {{24{lane[7] & sext}}, lane[7:0]};
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory-access stage with EX/MEM and MEM/WB registers
//   in  clk, reset (sync, active-low)
//   in  *E          execute-stage control and data
//   out RegWriteM, rdM, ALUResultM   EX/MEM contents for forwarding
//   out StallM      freezes upstream while a bus access waits
//   out dmem_*      data-memory request bus; in dmem_rdata, dmem_ready
//   out *W          MEM/WB contents, MisalignW / BusErrW exception flags
module mem_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        MemReadE,
    input  logic [1:0]  ResultSrcE,
    input  logic [2:0]  funct3E,
    input  logic [4:0]  rdE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCplus4E,
    output logic        RegWriteM,
    output logic [4:0]  rdM,
    output logic [31:0] ALUResultM,
    output logic        StallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  rdW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCplus4W,
    output logic        MisalignW,
    output logic        BusErrW
);
    logic        MemWriteM;
    logic        MemReadM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] WriteDataM;
    logic [31:0] PCplus4M;
    logic [31:0] load_data;
    logic        misalign;
    logic        memop;
    logic        bad_align;
    logic        abort;
    mem_state_t  state;
    logic [7:0]  cnt;

    lsu_align u_align (
        .funct3     (funct3M),
        .addr       (ALUResultM[1:0]),
        .wdata      (WriteDataM),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .store_data (dmem_wdata),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    assign memop     = MemReadM || MemWriteM;
    assign bad_align = misalign && memop;
    assign abort     = state == ABORT;
    // Request is combinational from EX/MEM so a zero-wait access completes in its first M cycle.
    assign dmem_req  = memop && !misalign && !abort;
    assign StallM    = dmem_req && !dmem_ready;
    assign dmem_we   = MemWriteM;
    assign dmem_addr = {ALUResultM[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!reset) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemReadM   <= 1'b0;
            ResultSrcM <= '0;
            funct3M    <= '0;
            rdM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCplus4M   <= '0;
        end else if (!StallM) begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            MemReadM   <= MemReadE;
            ResultSrcM <= ResultSrcE;
            funct3M    <= funct3E;
            rdM        <= rdE;
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            PCplus4M   <= PCplus4E;
        end
    end

    // cnt counts stalled cycles of the current access; the access is
    // dropped once it has stalled TIMEOUT_CYC cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (StallM) begin
                    state <= WAIT;
                    cnt   <= 8'd1;
                end
                WAIT: if (dmem_ready) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt   <= cnt + 8'd1;
                    state <= (cnt + 8'd1 == 8'(TIMEOUT_CYC)) ? ABORT : WAIT;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // A stalled cycle writes a bubble; data fields simply hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            rdW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCplus4W   <= '0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else if (StallM) begin
            RegWriteW  <= 1'b0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM && !bad_align && !abort;
            ResultSrcW <= ResultSrcM;
            rdW        <= rdM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_data;
            PCplus4W   <= PCplus4M;
            MisalignW  <= bad_align;
            BusErrW    <= abort;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage
module tb_mem_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, MemReadE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  funct3E;
    logic [4:0]  rdE;
    logic [31:0] ALUResultE, WriteDataE, PCplus4E;
    logic        RegWriteM;
    logic [4:0]  rdM;
    logic [31:0] ALUResultM;
    logic        StallM, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  rdW;
    logic [31:0] ALUResultW, ReadDataW, PCplus4W;
    logic        MisalignW, BusErrW;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
        .ResultSrcE(ResultSrcE), .funct3E(funct3E), .rdE(rdE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCplus4E(PCplus4E),
        .RegWriteM(RegWriteM), .rdM(rdM), .ALUResultM(ALUResultM),
        .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .rdW(rdW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCplus4W(PCplus4W),
        .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    // lat: stalled cycles before the bus answers; rst_at: M-cycle at which reset is pulsed (-1 none)
    typedef struct {
        logic rw, mw, mr;
        logic [1:0] rs;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [31:0] alu, wd, pc4, rdata;
        int lat, rst_at;
    } instr_t;

    typedef struct {
        logic rw;
        logic [1:0] rs;
        logic [4:0] rd;
        logic [31:0] alu, ld, pc4;
        logic mis, berr, chk;
    } exp_t;

    int checks = 0, errors = 0, pops = 0;
    exp_t q[$];
    bit go = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return f3[1] ? 4 : f3[0] ? 2 : 1;
    endfunction

    function automatic bit is_mem(input instr_t i);
        return i.mr || i.mw;
    endfunction

    function automatic bit is_mis(input instr_t i);
        return is_mem(i) && (int'(i.alu[1:0]) % nbytes(i.f3) != 0);
    endfunction

    function automatic bit is_abort(input instr_t i);
        return is_mem(i) && !is_mis(i) && i.lat >= TO;
    endfunction

    function automatic logic [31:0] load_val(input instr_t i);
        int n, off;
        logic [31:0] v, mask;
        n = nbytes(i.f3);
        off = int'(i.alu[1:0]);
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
        v = (i.rdata >> (8 * off)) & mask;
        if (n < 4 && !i.f3[2] && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic exp_t exp_of(input instr_t i);
        exp_t e;
        e.mis  = is_mis(i);
        e.berr = is_abort(i);
        e.rw   = i.rw && !e.mis && !e.berr;
        e.rs   = i.rs;
        e.rd   = i.rd;
        e.alu  = i.alu;
        e.pc4  = i.pc4;
        e.ld   = load_val(i);
        e.chk  = i.mr && !e.mis && !e.berr;
        return e;
    endfunction

    function automatic logic [3:0] be_of(input instr_t i);
        return 4'(((1 << nbytes(i.f3)) - 1) << int'(i.alu[1:0]));
    endfunction

    function automatic logic [31:0] wdata_of(input instr_t i);
        int n;
        n = nbytes(i.f3);
        return n == 4 ? i.wd : n == 2 ? 32'(i.wd[15:0]) * 32'h0001_0001 : 32'(i.wd[7:0]) * 32'h0101_0101;
    endfunction

    function automatic instr_t mk(input bit rw, input bit mw, input bit mr, input logic [1:0] rs,
                                  input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                                  input logic [31:0] rdata, input int lat, input int rst_at);
        instr_t i;
        i.rw = rw; i.mw = mw; i.mr = mr; i.rs = rs; i.f3 = f3; i.rd = 5'd7;
        i.alu = alu; i.wd = wd; i.pc4 = alu + 32'd4; i.rdata = rdata;
        i.lat = lat; i.rst_at = rst_at;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        logic [2:0] lf [5];
        int lat;
        lf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, TO - 1));
        i = mk(0, 0, 0, 2'b00, 3'($urandom), $urandom, $urandom, $urandom, lat, -1);
        i.rd = 5'($urandom);
        i.pc4 = $urandom;
        case ($urandom_range(0, 3))
            0: i.rw = 1;
            1: begin i.rw = 1; i.mr = 1; i.rs = 2'b01; i.f3 = lf[$urandom_range(0, 4)]; end
            2: begin i.mw = 1; i.rs = 2'($urandom); i.f3 = 3'($urandom_range(0, 2)); end
            default: begin i.rw = 1; i.rs = 2'b10; end
        endcase
        return i;
    endfunction

    task automatic drive(input instr_t i);
        RegWriteE = i.rw; MemWriteE = i.mw; MemReadE = i.mr; ResultSrcE = i.rs;
        funct3E = i.f3; rdE = i.rd; ALUResultE = i.alu; WriteDataE = i.wd; PCplus4E = i.pc4;
    endtask

    task automatic chk_w_zero(input string p);
        chk({p, "_req"}, dmem_req, 0);
        chk({p, "_stall"}, StallM, 0);
        chk({p, "_regwrite_w"}, RegWriteW, 0);
        chk({p, "_resultsrc_w"}, ResultSrcW, 0);
        chk({p, "_rd_w"}, rdW, 0);
        chk({p, "_alu_w"}, ALUResultW, 0);
        chk({p, "_read_w"}, ReadDataW, 0);
        chk({p, "_pc4_w"}, PCplus4W, 0);
        chk({p, "_misalign_w"}, MisalignW, 0);
        chk({p, "_buserr_w"}, BusErrW, 0);
    endtask

    initial begin
        instr_t m, e, zi;
        instr_t dir[$];
        int age;
        bit acc, exp_req;
        zi = mk(0, 0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 0, -1);
        zi.rd = 5'd0;
        zi.pc4 = 32'h0;
        dir.push_back(mk(1, 0, 1, 2'b01, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, -1));
        dir.push_back(mk(1, 0, 1, 2'b01, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1, -1));
        dir.push_back(mk(1, 0, 1, 2'b01, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, -1));
        dir.push_back(mk(0, 1, 0, 2'b00, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 3, -1));
        dir.push_back(mk(1, 0, 1, 2'b01, 3'b010, 32'h101, 32'h0, 32'h5555_5555, 0, -1));
        dir.push_back(mk(0, 1, 0, 2'b00, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 100, -1));
        dir.push_back(mk(0, 1, 0, 2'b00, 3'b010, 32'h400, 32'h1111_2222, 32'h0, 100, 2));
        dir.push_back(mk(1, 0, 0, 2'b00, 3'b000, 32'h5, 32'h0, 32'h0, 0, -1));
        reset = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        drive(mk(1, 1, 1, 2'b11, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, -1));
        repeat (3) @(posedge clk);
        #1;
        chk_w_zero("reset");
        chk("reset_regwrite_m", RegWriteM, 0);
        chk("reset_rd_m", rdM, 0);
        chk("reset_alu_m", ALUResultM, 0);
        q.push_back(exp_of(zi));
        e = zi; m = zi; age = 0; acc = 1;
        go = 1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            reset = 1'b1;
            if (acc) begin
                m = e; age = 0;
                e = dir.size() != 0 ? dir.pop_front() : rand_instr();
                drive(e);
            end else age++;
            dmem_rdata = m.rdata;
            if (m.rst_at == age) begin
                reset = 1'b0;
                dmem_ready = 1'b0;
                @(posedge clk);
                #1;
                chk_w_zero("midwait_reset");
                q.delete();
                q.push_back(exp_of(zi));
                m = zi; age = 0; acc = 0;
            end else begin
                dmem_ready = (is_mem(m) && !is_mis(m)) ? (age >= m.lat) : 1'($urandom);
                #3;
                exp_req = is_mem(m) && !is_mis(m) && age < TO;
                chk("dmem_req", dmem_req, exp_req);
                chk("stall_m", StallM, exp_req && age < m.lat);
                if (exp_req) begin
                    chk("dmem_addr", dmem_addr, m.alu & 32'hFFFF_FFFC);
                    chk("dmem_we", dmem_we, m.mw);
                    chk("dmem_be", dmem_be, be_of(m));
                    if (m.mw) chk("dmem_wdata", dmem_wdata, wdata_of(m));
                end
                acc = !StallM;
                if (acc) q.push_back(exp_of(e));
            end
        end
        @(negedge clk);
        chk("writeback_progress", pops > 100, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bit st, rs_;
        exp_t x;
        wait (go);
        forever begin
            @(negedge clk);
            #3;
            st = StallM;
            rs_ = reset;
            @(posedge clk);
            #1;
            if (rs_) begin
                if (st) begin
                    chk("bubble_regwrite_w", RegWriteW, 0);
                    chk("bubble_misalign_w", MisalignW, 0);
                    chk("bubble_buserr_w", BusErrW, 0);
                end else if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_queue: got writeback with no expected entry at %0t", $time);
                end else begin
                    x = q.pop_front();
                    pops++;
                    chk("regwrite_w", RegWriteW, x.rw);
                    chk("resultsrc_w", ResultSrcW, x.rs);
                    chk("rd_w", rdW, x.rd);
                    chk("alu_w", ALUResultW, x.alu);
                    chk("pc4_w", PCplus4W, x.pc4);
                    chk("misalign_w", MisalignW, x.mis);
                    chk("buserr_w", BusErrW, x.berr);
                    if (x.chk) chk("read_w", ReadDataW, x.ld);
                end
            end
        end
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32 pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and drives the data-memory bus through a req/ready handshake with a wait-state timeout.
- Aligns store data into byte lanes, and extracts and extends load data.
- Holds the MEM/WB register, and stalls the upstream stages while a bus access is pending.

Parameters:
- TIMEOUT_CYC, 16: maximum cycles dmem_req may wait for dmem_ready before the access is aborted (2..255).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- RegWriteE, MemWriteE, MemReadE  in  1 each  control bits from execute
- ResultSrcE  in  2  writeback mux select (00 ALU, 01 load data, 10 PC+4)
- funct3E  in  3  access size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- rdE  in  5  destination register
- ALUResultE  in  32  effective address, or ALU result
- WriteDataE  in  32  forwarded rs2 store data
- PCplus4E  in  32  link value
- RegWriteM, rdM, ALUResultM  out  1/5/32  EX/MEM contents, for the forwarding/hazard unit
- StallM  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- dmem_req, dmem_we  out  1 each  bus request; write enable
- dmem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid when dmem_ready=1
- dmem_ready  in  1  transfer completes in a cycle where dmem_req && dmem_ready
- RegWriteW, ResultSrcW, rdW  out  1/2/5  MEM/WB control
- ALUResultW, ReadDataW, PCplus4W  out  32 each  MEM/WB data
- MisalignW, BusErrW  out  1 each  exception flags toward writeback/trap logic

Behaviour:
- Reset, on a clk edge with reset=0:
  - every EX/MEM and MEM/WB field is 0, FSM is IDLE, wait counter is 0.
  - Resulting outputs: dmem_req=0, StallM=0, all *W outputs 0.
- EX/MEM register: captures all E inputs when StallM=0; holds when StallM=1.
- Definitions:
  - memop = MemReadM | MemWriteM.
  - misalign = (halfword && addr[0]) || (word && addr[1:0]!=0).
- dmem_req = memop && !misalign && state!=ABORT. This is combinational from the EX/MEM register, so a zero-wait access is presented in the same cycle the instruction enters M.
- StallM = dmem_req && !dmem_ready.
- FSM:
  - IDLE: dmem_req && !dmem_ready -> WAIT, counter=1.
  - WAIT: dmem_ready -> IDLE.
  - WAIT, otherwise: counter++. When counter reaches TIMEOUT_CYC, go to ABORT.
  - ABORT: dmem_req=0 and StallM=0 for one cycle; the instruction advances with BusErrW=1. Next state IDLE.
- Stores: dmem_we=MemWriteM.
  - SB: be = 0001 << addr[1:0], wdata = byte replicated x4.
  - SH: be = 0011 << addr[1:0], wdata = halfword replicated x2.
  - SW: be=1111.
- Loads: dmem_be follows the same size rule. The selected lane is sign-extended (LB/LH) or zero-extended (LBU/LHU) into ReadDataW.
- MEM/WB register, when StallM=0:
  - captures the M control/data, plus the formatted load data.
  - MisalignW=misalign&&memop.
  - BusErrW=1 only on the ABORT cycle.
  - RegWriteW is forced to 0 if the misalign or abort condition holds.
- MEM/WB register, when StallM=1: a bubble is written (RegWriteW=0, flags 0; data fields don't-care, held).
- A misaligned access never asserts dmem_req, and a misaligned store never writes memory.
- Non-memory instruction: passes through M->W in exactly 1 cycle with no stall.
- Reset mid-WAIT: the request drops the cycle after reset; no partial writeback occurs.
- dmem_ready while dmem_req=0: ignored.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 load/store encodings
  - ResultSrc encodings
  - the FSM state enum (IDLE, WAIT, ABORT)
- Sub-module lsu_align: combinational. Computes byte enables, replicated store data, load extract/extend and the misalign flag from funct3, addr[1:0], wdata and rdata.

Test Plan:
- LW, addr 0x100, dmem_ready held 1, rdata 0xDEADBEEF -> req for one cycle, StallM never 1, next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
- LB, addr 0x103, rdata 0x80FF_0000; then LBU at the same address -> ReadDataW=0xFFFFFF80, then 0x00000080.
- SH, addr 0x202, WriteData 0x1234ABCD, ready after 3 wait cycles -> be=1100, wdata=0xABCDABCD, StallM=1 for 3 cycles, then a bubble in W during the stall.
- LW, addr 0x101 -> dmem_req stays 0, MisalignW=1, RegWriteW=0, no stall.
- SW with dmem_ready never asserted, TIMEOUT_CYC=4 -> StallM high 4 cycles, ABORT cycle, BusErrW=1, FSM back in IDLE.
- reset=0 asserted during WAIT -> next cycle dmem_req=0, all *W=0; after release an ADD result 0x5 reaches ALUResultW with no stall.
